// File: rtl/gn_arbiter_pkg.sv
// Shared types and helpers for the golden-nonce arbiter: FSM states,
// drop-counter width and the round-robin search used to pick the next slot.
package gn_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2
  } gn_state_e;

  localparam int DROP_W    = 8;
  localparam int MAX_CORES = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set request at or after ptr, wrapping modulo n (n <= MAX_CORES).
  function automatic rr_pick_t rr_pick(input logic [MAX_CORES-1:0] req,
                                       input logic [2:0] ptr, input int n);
    rr_pick_t r;
    int       j;
    r.found = 1'b0;
    r.idx   = 3'd0;
    for (int k = 0; k < MAX_CORES; k++) begin
      j = (int'(ptr) + k) % n;
      if ((k < n) && !r.found && req[j]) begin
        r.found = 1'b1;
        r.idx   = 3'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/gn_arbiter_if.sv
// Result stream from the arbiter to the comms transmitter (valid/ready).
interface gn_arbiter_if #(parameter int CORE_W = 2);
  logic [31:0]       gn_data;
  logic [CORE_W-1:0] gn_core;
  logic              gn_valid;
  logic              gn_ready;

  modport master (output gn_data, output gn_core, output gn_valid, input gn_ready);
  modport slave  (input gn_data, input gn_core, input gn_valid, output gn_ready);
endinterface

// File: rtl/gn_fifo.sv
// Small synchronous FIFO for arbitrated results; flush empties it in one cycle.
module gn_fifo #(
  parameter  int W     = 34,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign full     = (r_count == CW'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign pop_data = r_mem[r_rd];
  assign w_push   = push && !full && !flush;
  assign w_pop    = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= push_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/gn_arbiter.sv
// Multicore sequencer and golden-nonce arbiter: broadcasts core resets and
// drains per-core result slots round-robin. Optional macro: GN_DROP_CNT_EN.
module gn_arbiter
  import gn_arbiter_pkg::*;
#(
  parameter  int NUM_CORES  = 4,
  parameter  int FIFO_DEPTH = 4,
  parameter  int RST_CYCLES = 4,
  localparam int CORE_W     = $clog2(NUM_CORES)
) (
  input  logic                   hash_clk,
  input  logic                   reset_n,
  input  logic                   new_work,
  output logic [NUM_CORES-1:0]   core_reset,
  input  logic [32*NUM_CORES-1:0] core_gn,
  input  logic [NUM_CORES-1:0]   core_gn_match,
  input  logic [NUM_CORES-1:0]   core_busy,
  gn_arbiter_if.master           gn_if,
  output logic                   miner_busy,
  output logic [DROP_W-1:0]      drop_cnt
);

  localparam int CNT_W = $clog2(RST_CYCLES);
  localparam int FW    = 32 + CORE_W;
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

  gn_state_e              r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_rst_cnt, w_rst_cnt_nxt;
  logic [NUM_CORES-1:0]   r_slot_full;
  logic [31:0]            r_slot_data [NUM_CORES];
  logic [CORE_W-1:0]      r_ptr;
  logic [MAX_CORES-1:0]   w_req;
  rr_pick_t               w_pick;
  logic                   w_grant;
  logic [NUM_CORES-1:0]   w_gi;
  logic                   w_cap_en;
  logic [FW-1:0]          w_head;
  logic                   w_full, w_empty;
  logic [FCW-1:0]         w_count;

  assign w_cap_en   = (r_state != RESET) && !new_work;
  assign core_reset = {NUM_CORES{r_state == RESET}};
  assign miner_busy = (r_state != IDLE) || !w_empty;

  assign gn_if.gn_valid = !w_empty;
  assign gn_if.gn_data  = w_head[31:0];
  assign gn_if.gn_core  = w_head[FW-1:32];

  // FSM state and reset-pulse counter
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_rst_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rst_cnt <= w_rst_cnt_nxt;
    end
  end

  // FSM next state; new_work overrides every state
  always_comb begin
    w_state_nxt   = r_state;
    w_rst_cnt_nxt = r_rst_cnt;
    if (new_work) begin
      w_state_nxt   = RESET;
      w_rst_cnt_nxt = CNT_W'(RST_CYCLES - 1);
    end else begin
      case (r_state)
        RESET: begin
          if (r_rst_cnt == '0) w_state_nxt = RUN;
          else w_rst_cnt_nxt = r_rst_cnt - CNT_W'(1);
        end
        RUN: begin
          if ((core_busy == '0) && (r_slot_full == '0) && (w_count == '0)) w_state_nxt = IDLE;
          else w_state_nxt = RUN;
        end
        IDLE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Round-robin grant of one full slot whenever the FIFO has room
  always_comb begin
    w_req                  = '0;
    w_req[NUM_CORES-1:0]   = r_slot_full;
    w_pick                 = rr_pick(w_req, 3'(r_ptr), NUM_CORES);
    w_grant                = w_pick.found && !w_full && !new_work;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_gi[i] = w_grant && (w_pick.idx == 3'(i));
    end
  end

  // Slot capture; a granted slot may refill from a same-cycle strobe
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slot_full <= '0;
      for (int i = 0; i < NUM_CORES; i++) r_slot_data[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (new_work) begin
          r_slot_full[i] <= 1'b0;
        end else if (w_cap_en && core_gn_match[i] && (!r_slot_full[i] || w_gi[i])) begin
          r_slot_full[i] <= 1'b1;
          r_slot_data[i] <= core_gn[32*i +: 32];
        end else if (w_gi[i]) begin
          r_slot_full[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer moves past the granted slot
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) r_ptr <= '0;
    else if (new_work) r_ptr <= '0;
    else if (w_grant) r_ptr <= w_pick.idx[CORE_W-1:0] + CORE_W'(1);
  end

  gn_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (hash_clk),
    .rst_n     (reset_n),
    .flush     (new_work),
    .push      (w_grant),
    .push_data ({w_pick.idx[CORE_W-1:0], r_slot_data[w_pick.idx[CORE_W-1:0]]}),
    .pop       (gn_if.gn_ready),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

`ifdef GN_DROP_CNT_EN
  logic [NUM_CORES-1:0] w_drop;
  logic [DROP_W:0]      w_drop_sum;
  logic [DROP_W-1:0]    r_drop_cnt;

  // Several cores can lose a nonce in the same cycle
  always_comb begin
    w_drop     = {NUM_CORES{w_cap_en}} & core_gn_match & r_slot_full & ~w_gi;
    w_drop_sum = {1'b0, r_drop_cnt};
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_drop[i]) w_drop_sum = w_drop_sum + (DROP_W+1)'(1);
      else w_drop_sum = w_drop_sum;
    end
  end

  // Saturating lost-nonce counter, survives new_work
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) r_drop_cnt <= '0;
    else r_drop_cnt <= w_drop_sum[DROP_W] ? {DROP_W{1'b1}} : w_drop_sum[DROP_W-1:0];
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_gn_arbiter.sv
// Directed bench for gn_arbiter: per-cycle vector table plus hand sequences
// for drops, saturation, grant/refill and new_work retrigger.
module tb_gn_arbiter;

  localparam int N  = 4;
  localparam int CW = 2;
`ifdef GN_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic            hash_clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            new_work = 1'b0;
  logic            gn_ready = 1'b0;
  logic [N-1:0]    core_reset;
  logic [N-1:0]    core_gn_match = '0;
  logic [N-1:0]    core_busy = '0;
  logic [32*N-1:0] core_gn = '0;
  logic            miner_busy;
  logic [7:0]      drop_cnt;
  int              errors = 0;
  int              checks = 0;

  gn_arbiter_if #(.CORE_W(CW)) gn_if ();
  assign gn_if.gn_ready = gn_ready;

  gn_arbiter #(.NUM_CORES(N), .FIFO_DEPTH(4), .RST_CYCLES(4)) dut (
    .hash_clk      (hash_clk),
    .reset_n       (reset_n),
    .new_work      (new_work),
    .core_reset    (core_reset),
    .core_gn       (core_gn),
    .core_gn_match (core_gn_match),
    .core_busy     (core_busy),
    .gn_if         (gn_if),
    .miner_busy    (miner_busy),
    .drop_cnt      (drop_cnt)
  );

  always #5 hash_clk = ~hash_clk;

  typedef struct {
    logic        nw;
    logic [3:0]  match;
    logic [31:0] base;
    logic        rdy;
    logic [3:0]  busy;
    logic [3:0]  e_creset;
    logic        e_mbusy;
    logic        e_valid;
    logic [31:0] e_data;
    logic [1:0]  e_core;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic nw, logic [3:0] m, logic [31:0] b, logic r, logic [3:0] bz,
                              logic [3:0] ecr, logic emb, logic ev, logic [31:0] ed, logic [1:0] ec);
    vec_t v;
    v.nw = nw; v.match = m; v.base = b; v.rdy = r; v.busy = bz;
    v.e_creset = ecr; v.e_mbusy = emb; v.e_valid = ev; v.e_data = ed; v.e_core = ec;
    return v;
  endfunction

  function automatic logic [7:0] dexp(input int v);
    return DROP_EN ? 8'(v) : 8'd0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge hash_clk);
    #1;
  endtask

  task automatic set_gn(input logic [31:0] base);
    for (int i = 0; i < N; i++) core_gn[32*i +: 32] = base + 32'(i);
  endtask

  task automatic strobe(input logic [3:0] m, input logic [31:0] base);
    set_gn(base);
    core_gn_match = m;
    step();
    core_gn_match = '0;
  endtask

  task automatic start_run();
    new_work = 1'b1;
    step();
    new_work = 1'b0;
    repeat (4) step();
    chk("start_run core_reset low", 64'(core_reset), 64'd0);
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic [1:0] c, input string nm);
    int n = 0;
    while (!gn_if.gn_valid && n < 10) begin
      step();
      n++;
    end
    chk({nm, " valid"}, 64'(gn_if.gn_valid), 64'd1);
    chk({nm, " data"}, 64'(gn_if.gn_data), 64'(d));
    chk({nm, " core"}, 64'(gn_if.gn_core), 64'(c));
    step();
  endtask

  initial begin
    int n;
    // reset state
    repeat (2) step();
    chk("rst core_reset", 64'(core_reset), 64'd0);
    chk("rst gn_valid", 64'(gn_if.gn_valid), 64'd0);
    chk("rst gn_data", 64'(gn_if.gn_data), 64'd0);
    chk("rst gn_core", 64'(gn_if.gn_core), 64'd0);
    chk("rst miner_busy", 64'(miner_busy), 64'd0);
    chk("rst drop_cnt", 64'(drop_cnt), 64'd0);
    reset_n = 1'b1;
    step();

    // nw  match base           rdy  busy  | creset mbusy valid data          core
    tbl.push_back(mk(1'b1, 4'h0, 32'h0,        1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 32'h0, 2'd0));
    tbl.push_back(mk(1'b0, 4'h0, 32'h0,        1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 32'h0, 2'd0));
    tbl.push_back(mk(1'b0, 4'h0, 32'h0,        1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 32'h0, 2'd0));
    tbl.push_back(mk(1'b0, 4'h0, 32'h0,        1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 32'h0, 2'd0));
    tbl.push_back(mk(1'b0, 4'h0, 32'h0,        1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 32'h0, 2'd0));
    tbl.push_back(mk(1'b0, 4'h4, 32'h7fbd9205, 1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 32'h0, 2'd0));
    tbl.push_back(mk(1'b0, 4'h0, 32'h7fbd9205, 1'b1, 4'hF, 4'h0, 1'b1, 1'b1, 32'h7fbd9207, 2'd2));
    tbl.push_back(mk(1'b0, 4'h0, 32'h0,        1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 32'h0, 2'd0));
    tbl.push_back(mk(1'b0, 4'h0, 32'h0,        1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0, 2'd0));
    tbl.push_back(mk(1'b1, 4'h0, 32'h0,        1'b0, 4'h0, 4'hF, 1'b1, 1'b0, 32'h0, 2'd0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1'b0, 4'h0, 32'h0,      1'b0, 4'h0, 4'hF, 1'b1, 1'b0, 32'h0, 2'd0));
    tbl.push_back(mk(1'b0, 4'h0, 32'h0,        1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0, 2'd0));
    tbl.push_back(mk(1'b0, 4'hF, 32'h10000000, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0, 2'd0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1'b0, 4'h0, 32'h0,      1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 32'h10000000, 2'd0));
    for (int k = 1; k < 4; k++)
      tbl.push_back(mk(1'b0, 4'h0, 32'h0,      1'b1, 4'h0, 4'h0, 1'b1, 1'b1, 32'h10000000 + 32'(k), 2'(k)));
    tbl.push_back(mk(1'b0, 4'h0, 32'h0,        1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0, 2'd0));

    foreach (tbl[k]) begin
      new_work      = tbl[k].nw;
      core_gn_match = tbl[k].match;
      set_gn(tbl[k].base);
      gn_ready      = tbl[k].rdy;
      core_busy     = tbl[k].busy;
      step();
      chk($sformatf("row%0d core_reset", k), 64'(core_reset), 64'(tbl[k].e_creset));
      chk($sformatf("row%0d miner_busy", k), 64'(miner_busy), 64'(tbl[k].e_mbusy));
      chk($sformatf("row%0d gn_valid", k), 64'(gn_if.gn_valid), 64'(tbl[k].e_valid));
      if (tbl[k].e_valid) begin
        chk($sformatf("row%0d gn_data", k), 64'(gn_if.gn_data), 64'(tbl[k].e_data));
        chk($sformatf("row%0d gn_core", k), 64'(gn_if.gn_core), 64'(tbl[k].e_core));
      end
    end
    new_work = 1'b0;
    core_gn_match = '0;
    chk("table drop_cnt", 64'(drop_cnt), 64'd0);

    // grant of slot 3 coinciding with a fresh strobe on core 3
    gn_ready  = 1'b0;
    core_busy = 4'hF;
    start_run();
    strobe(4'h8, 32'h60000000);
    strobe(4'h8, 32'h70000000);
    gn_ready = 1'b1;
    expect_beat(32'h60000003, 2'd3, "refill beat0");
    expect_beat(32'h70000003, 2'd3, "refill beat1");
    chk("refill drop_cnt", 64'(drop_cnt), 64'd0);

    // drop with full FIFO and full slot 1, then saturation
    gn_ready = 1'b0;
    start_run();
    strobe(4'hF, 32'h20000000);
    repeat (4) step();
    strobe(4'h2, 32'h30000000);
    chk("pre-drop drop_cnt", 64'(drop_cnt), 64'd0);
    strobe(4'h2, 32'h40000000);
    chk("first drop drop_cnt", 64'(drop_cnt), 64'(dexp(1)));
    set_gn(32'h50000000);
    core_gn_match = 4'h2;
    repeat (300) step();
    core_gn_match = '0;
    chk("saturated drop_cnt", 64'(drop_cnt), 64'(dexp(255)));
    gn_ready = 1'b1;
    for (int k = 0; k < 4; k++)
      expect_beat(32'h20000000 + 32'(k), 2'(k), $sformatf("drain beat%0d", k));
    expect_beat(32'h30000001, 2'd1, "kept slot1 nonce");
    repeat (3) step();
    chk("drain empty", 64'(gn_if.gn_valid), 64'd0);

    // reset clears drop_cnt, then new_work retrigger with full FIFO and slots
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("re-reset drop_cnt", 64'(drop_cnt), 64'd0);
    gn_ready = 1'b0;
    start_run();
    strobe(4'hF, 32'h80000000);
    repeat (4) step();
    strobe(4'hF, 32'h90000000);
    chk("pre-retrigger gn_valid", 64'(gn_if.gn_valid), 64'd1);
    new_work = 1'b1;
    step();
    new_work = 1'b0;
    chk("retrigger gn_valid", 64'(gn_if.gn_valid), 64'd0);
    chk("retrigger core_reset", 64'(core_reset), 64'hF);
    strobe(4'hF, 32'hA0000000);
    strobe(4'hF, 32'hB0000000);
    new_work = 1'b1;
    step();
    new_work = 1'b0;
    n = 0;
    while (core_reset == 4'hF && n < 20) begin
      n++;
      step();
    end
    chk("restarted core_reset cycles", 64'(n), 64'd4);
    gn_ready = 1'b1;
    repeat (6) step();
    chk("no output after reset strobes", 64'(gn_if.gn_valid), 64'd0);
    chk("no drop during RESET", 64'(drop_cnt), 64'd0);
    chk("busy while cores busy", 64'(miner_busy), 64'd1);
    core_busy = 4'h0;
    repeat (2) step();
    chk("idle miner_busy", 64'(miner_busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
